ram2_pingpong_ctrl: RTL and testbench
=====================================

// Module: ram2_pingpong_ctrl
// PURPOSE
//  Ping-pong frame controller for the ram2 simple dual-port RAM in the audio FFT/FIR path.
//  Splits the RAM into two banks of 2**(ADDR_WIDTH-1) words and writes the audio sample
//  stream into one bank while the other is read out. Full banks drain to a valid/ready
//  consumer (FFT input) with out_last on each frame's final word. Covers RAM read latency.
// PARAMETERS
//  ADDR_WIDTH   8    RAM address width; MSB selects bank, BANK_WORDS = 2**(ADDR_WIDTH-1)
//  DATA_WIDTH   32   sample / RAM word width
//  RD_LATENCY   2    RAM rd_addr->rd_data latency in clk cycles (2 = OUT_REG on), range 1..4
// PORTS
//  clk          in   1            single clock; RAM wr_clk and rd_clk both tie to clk
//  rst          in   1            asynchronous, active-high reset
//  in_data      in   DATA_WIDTH   sample; no backpressure
//  in_valid     in   1            sample strobe
//  out_data     out  DATA_WIDTH   frame word to consumer
//  out_valid    out  1            out_data valid
//  out_ready    in   1            consumer accepts when out_valid&out_ready
//  out_last     out  1            high with final word (index BANK_WORDS-1) of a frame
//  overflow     out  1            sticky: a sample was dropped; cleared only by rst
//  ram_wr_en    out  1            to ram2 wr_en
//  ram_wr_addr  out  ADDR_WIDTH   to ram2 wr_addr, {wbank, waddr}
//  ram_wr_data  out  DATA_WIDTH   to ram2 wr_data
//  ram_rd_addr  out  ADDR_WIDTH   to ram2 rd_addr, {rbank, raddr}
//  ram_rd_data  in   DATA_WIDTH   from ram2 rd_data
// BEHAVIOUR
//  Reset: all outputs 0; full[1:0]=0, wbank=rbank=0, waddr=raddr=0, FIFO empty, reader IDLE.
//  Writer: sample accepted when in_valid & bank wbank free (full[wbank]=0, or being freed
//   this same cycle - free wins). Accepted sample -> ram_wr_en/addr/data registered, 1 cycle.
//   Accept at waddr=BANK_WORDS-1: full[wbank]<=1, wbank toggles, waddr<=0; else waddr+1.
//   in_valid while wbank full and not being freed: sample dropped, waddr held, overflow<=1.
//  Reader FSM:
//   IDLE : full[rbank]=1 -> READ, raddr=0.
//   READ : issue one read/cycle when inflight + fifo_count < FIFO_DEPTH (=RD_LATENCY+2);
//          issue = drive {rbank,raddr}, push 1 into RD_LATENCY-deep valid shift register,
//          raddr+1. Issue of raddr=BANK_WORDS-1 -> DRAIN.
//   DRAIN: no issues; on out_valid&out_ready&out_last -> full[rbank]<=0, rbank toggles, IDLE.
//  RAM has no rd_en: ram_rd_addr holds last value when not issuing; only shift-register-tagged
//   ram_rd_data words are captured into the output FIFO (registered head = out_data/out_valid).
//  FIFO never overflows (credit rule); sustained 1 word/cycle when out_ready held high.
//  out_last: per-word tag set for raddr=BANK_WORDS-1, carried through pipeline and FIFO.
//  Order preserved; no loss or duplication under any out_ready pattern.
//  Latency: last write accepted in cycle T -> out_valid first high in cycle T+RD_LATENCY+3.
//  Writer and reader operate on different banks; full bits set/cleared independently same cycle.
//  out_valid held with stable out_data/out_last until accepted.
//  rst mid-frame: everything returns to reset state at once; partial frames discarded.
// TESTING
//  T1 reset: rst high 200 ns, random in_valid -> all outputs 0, ram_wr_en never high.
//  T2 single frame: 128 samples value k (k=0..127), out_ready=1 -> out_data 0..127 back-to-back,
//     out_last only on 127, first out_valid exactly RD_LATENCY+3 cycles after last accept.
//  T3 backpressure: out_ready 1,0 alternating and random -> same 0..127 sequence, no dup/loss,
//     out_data stable while out_valid&!out_ready.
//  T4 overflow: out_ready=0, 300 samples k=0..299 -> ram_wr_en pulses 256 times, overflow=1
//     from sample 256; then out_ready=1 -> frames 0..127 then 128..255, samples 256..299 lost.
//  T5 free/write collision: hold reader stalled so writer reaches full bank in the exact cycle
//     final out_last is accepted -> that sample accepted to waddr 0, overflow stays 0.
//  T6 reset mid-read: rst at out word 50 -> outputs 0, next 128 samples go to bank 0 addr 0
//     and read out as a clean frame; repeat with RD_LATENCY=1 and 4.

Source files
------------

// File: rtl/ram2_pingpong_ctrl.sv
// ram2_pingpong_ctrl: two-bank ping-pong frame controller for the ram2 dual-port RAM.
// One bank fills from the sample stream while the other drains to a valid/ready sink.
module ram2_pingpong_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  overflow,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);
    localparam int AW1 = ADDR_WIDTH - 1;
    localparam int FIFO_DEPTH = RD_LATENCY + 2;
    // Storage behind the registered head word
    localparam int SDEPTH = FIFO_DEPTH - 1;
    localparam int PW = $clog2(SDEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;
    localparam logic [AW1-1:0] LAST_IDX = '1;
    localparam logic [CW-1:0] FD_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [1:0]            r_full;
    logic [1:0]            w_full_nxt;
    logic                  r_wbank;
    logic                  r_rbank;
    logic [AW1-1:0]        r_waddr;
    logic [AW1-1:0]        r_raddr;
    logic [ADDR_WIDTH-1:0] r_rd_addr_q;
    logic [RD_LATENCY-1:0] r_vsr;
    logic [RD_LATENCY-1:0] r_lsr;
    logic [DATA_WIDTH-1:0] r_sd [SDEPTH];
    logic                  r_sl [SDEPTH];
    logic [PW-1:0]         r_srd;
    logic [PW-1:0]         r_swr;
    logic [CW-1:0]         r_scnt;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_ovf;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;

    logic          w_issue;
    logic          w_free;
    logic          w_accept;
    logic          w_pop;
    logic          w_cap;
    logic          w_cap_last;
    logic          w_head_free;
    logic          w_spush;
    logic          w_spop;
    logic          w_credit_ok;
    logic [CW-1:0] w_inflight;
    logic [CW-1:0] w_fifo_cnt;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(SDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++)
            w_inflight = w_inflight + CW'(r_vsr[i]);
    end

    assign w_fifo_cnt  = r_scnt + CW'(r_out_valid);
    assign w_credit_ok = (w_inflight + w_fifo_cnt) < FD_C;
    assign w_pop       = r_out_valid & out_ready;
    assign w_cap       = r_vsr[RD_LATENCY-1];
    assign w_cap_last  = r_lsr[RD_LATENCY-1];
    assign w_head_free = ~r_out_valid | w_pop;
    assign w_spop      = w_head_free & (r_scnt != '0);
    assign w_spush     = w_cap & ~(w_head_free & (r_scnt == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_free      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (r_full[r_rbank])
                    w_state_nxt = S_READ;
            end
            S_READ: begin
                w_issue = w_credit_ok;
                if (w_credit_ok && r_raddr == LAST_IDX)
                    w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_pop && r_out_last) begin
                    w_free      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A bank released by the reader this cycle is already writable
    assign w_accept = in_valid &
        (~r_full[r_wbank] | (w_free & (r_rbank == r_wbank)));

    always_comb begin
        w_full_nxt = r_full;
        if (w_free)
            w_full_nxt[r_rbank] = 1'b0;
        if (w_accept && r_waddr == LAST_IDX)
            w_full_nxt[r_wbank] = 1'b1;
    end

    assign ram_rd_addr = w_issue ? {r_rbank, r_raddr} : r_rd_addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full      <= '0;
            r_wbank     <= 1'b0;
            r_rbank     <= 1'b0;
            r_waddr     <= '0;
            r_raddr     <= '0;
            r_rd_addr_q <= '0;
            r_vsr       <= '0;
            r_lsr       <= '0;
            r_srd       <= '0;
            r_swr       <= '0;
            r_scnt      <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_ovf       <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_full  <= w_full_nxt;
            r_wr_en <= w_accept;
            if (w_accept) begin
                r_wr_addr <= {r_wbank, r_waddr};
                r_wr_data <= in_data;
                r_waddr   <= r_waddr + 1'b1;
                if (r_waddr == LAST_IDX)
                    r_wbank <= ~r_wbank;
            end
            if (in_valid && !w_accept)
                r_ovf <= 1'b1;
            if (w_issue) begin
                r_raddr     <= r_raddr + 1'b1;
                r_rd_addr_q <= ram_rd_addr;
            end
            if (w_free)
                r_rbank <= ~r_rbank;
            r_vsr <= (r_vsr << 1) | RD_LATENCY'(w_issue);
            r_lsr <= (r_lsr << 1) |
                RD_LATENCY'(w_issue && r_raddr == LAST_IDX);
            if (w_head_free) begin
                if (r_scnt != '0) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= r_sd[r_srd];
                    r_out_last  <= r_sl[r_srd];
                end else if (w_cap) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= ram_rd_data;
                    r_out_last  <= w_cap_last;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end
            if (w_spop)
                r_srd <= f_inc(r_srd);
            if (w_spush)
                r_swr <= f_inc(r_swr);
            r_scnt <= r_scnt + CW'(w_spush) - CW'(w_spop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_spush) begin
            r_sd[r_swr] <= ram_rd_data;
            r_sl[r_swr] <= w_cap_last;
        end
    end

    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign out_last    = r_out_last;
    assign overflow    = r_ovf;
    assign ram_wr_en   = r_wr_en;
    assign ram_wr_addr = r_wr_addr;
    assign ram_wr_data = r_wr_data;

endmodule

// File: tb/tb_ram2_pingpong_ctrl.sv
// tb_ram2_pingpong_ctrl: three controllers (RD_LATENCY 1, 2, 4) on shared stimulus,
// each scored against a frame-queue model of the ping-pong rules.
module tb_ram2_pingpong_ctrl;
    localparam int NI = 3;
    localparam int BW = 128;
    localparam int QN = 2048;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [31:0]          in_data;
    logic                 in_valid;
    logic [NI-1:0][31:0]  out_data;
    logic [NI-1:0]        out_valid;
    logic [NI-1:0]        out_ready;
    logic [NI-1:0]        out_last;
    logic [NI-1:0]        overflow;
    logic [NI-1:0]        ram_wr_en;
    logic [NI-1:0][7:0]   ram_wr_addr;
    logic [NI-1:0][31:0]  ram_wr_data;
    logic [NI-1:0][7:0]   ram_rd_addr;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        logic [31:0] mem [256];
        logic [31:0] pipe [LAT];
        logic [31:0] rdd;

        ram2_pingpong_ctrl #(
            .ADDR_WIDTH(8),
            .DATA_WIDTH(32),
            .RD_LATENCY(LAT)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_data    (in_data),
            .in_valid   (in_valid),
            .out_data   (out_data[g]),
            .out_valid  (out_valid[g]),
            .out_ready  (out_ready[g]),
            .out_last   (out_last[g]),
            .overflow   (overflow[g]),
            .ram_wr_en  (ram_wr_en[g]),
            .ram_wr_addr(ram_wr_addr[g]),
            .ram_wr_data(ram_wr_data[g]),
            .ram_rd_addr(ram_rd_addr[g]),
            .ram_rd_data(rdd)
        );

        // ram2 behaviour: write and read on clk, LAT-cycle read pipeline
        always @(posedge clk) begin
            if (ram_wr_en[g])
                mem[ram_wr_addr[g]] <= ram_wr_data[g];
            pipe[0] <= mem[ram_rd_addr[g]];
            for (int k = 1; k < LAT; k++)
                pipe[k] <= pipe[k-1];
        end
        assign rdd = pipe[LAT-1];
    end

    int          cyc;
    int          n_cmp;
    int          n_bad;
    int          rmode;
    logic        lat_arm;
    logic [31:0] exp_d [NI][QN];
    int          m_wr [NI];
    int          m_rd [NI];
    int          m_fill [NI];
    int          m_full [NI];
    int          m_done [NI];
    int          n_we [NI];
    int          acc_cyc [NI];
    logic        lat_pend [NI];
    logic        e_we [NI];
    logic        e_ov [NI];
    logic [7:0]  e_wa [NI];
    logic [31:0] e_wd [NI];
    logic        stall [NI];
    logic [31:0] stall_d [NI];

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 2 : 4;
    endfunction

    task automatic chk(input string tag, input int i,
                       input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s[%0d]: got %0h, want %0h", tag, i, obs, exp);
        end
    endtask

    task automatic model_reset(input int i);
        m_wr[i]     = 0;
        m_rd[i]     = 0;
        m_fill[i]   = 0;
        m_full[i]   = 0;
        m_done[i]   = 0;
        n_we[i]     = 0;
        e_we[i]     = 1'b0;
        e_ov[i]     = 1'b0;
        e_wa[i]     = '0;
        e_wd[i]     = '0;
        stall[i]    = 1'b0;
        stall_d[i]  = '0;
        lat_pend[i] = 1'b0;
    endtask

    task automatic observe();
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                chk("rst_flags", i, 32'({out_valid[i], out_last[i],
                    overflow[i], ram_wr_en[i]}), 32'd0);
                chk("rst_data", i, out_data[i] | ram_wr_data[i], 32'd0);
                chk("rst_addr", i,
                    32'({ram_wr_addr[i], ram_rd_addr[i]}), 32'd0);
                model_reset(i);
            end else begin
                n_we[i] += int'(ram_wr_en[i]);
                chk("wr_en", i, 32'(ram_wr_en[i]), 32'(e_we[i]));
                if (e_we[i]) begin
                    chk("wr_addr", i, 32'(ram_wr_addr[i]), 32'(e_wa[i]));
                    chk("wr_data", i, ram_wr_data[i], e_wd[i]);
                end
                chk("overflow", i, 32'(overflow[i]), 32'(e_ov[i]));
                if (stall[i])
                    chk("stable", i, out_data[i], stall_d[i]);
                if (out_valid[i]) begin
                    chk("avail", i, 32'(m_rd[i] < m_wr[i]), 32'd1);
                    if (m_rd[i] < m_wr[i]) begin
                        chk("out_data", i, out_data[i], exp_d[i][m_rd[i]]);
                        chk("out_last", i, 32'(out_last[i]),
                            32'((m_rd[i] % BW) == BW - 1));
                    end
                    if (lat_pend[i]) begin
                        chk("latency", i, 32'(cyc - acc_cyc[i]),
                            32'(lat_of(i) + 3));
                        lat_pend[i] = 1'b0;
                    end
                end
                stall[i]   = out_valid[i] & ~out_ready[i];
                stall_d[i] = out_data[i];
                // The reader frees a bank before the writer looks at it
                if (out_valid[i] && out_ready[i]) begin
                    if ((m_rd[i] % BW) == BW - 1)
                        m_full[i]--;
                    m_rd[i]++;
                end
                e_we[i] = 1'b0;
                if (in_valid) begin
                    if (m_full[i] < 2) begin
                        e_we[i] = 1'b1;
                        e_wa[i] = 8'(m_done[i] % 2 * BW + m_fill[i]);
                        e_wd[i] = in_data;
                        exp_d[i][m_wr[i] + m_fill[i]] = in_data;
                        m_fill[i]++;
                        if (m_fill[i] == BW) begin
                            m_fill[i] = 0;
                            m_wr[i] += BW;
                            m_full[i]++;
                            m_done[i]++;
                            if (lat_arm) begin
                                acc_cyc[i]  = cyc;
                                lat_pend[i] = 1'b1;
                            end
                        end
                    end else begin
                        e_ov[i] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        for (int i = 0; i < NI; i++) begin
            case (rmode)
                0: out_ready[i] = 1'b0;
                1: out_ready[i] = 1'b1;
                2: out_ready[i] = cyc[0];
                3: out_ready[i] = 1'($urandom_range(1));
                default: out_ready[i] = ~(out_valid[i] & out_last[i]);
            endcase
        end
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input int n, input logic [31:0] base, input int gap);
        for (int k = 0; k < n; k++) begin
            if (gap > 0 && $urandom_range(99) < gap) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                tick();
            end
            in_valid = 1'b1;
            in_data  = base + 32'(k);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int   n;
        logic done;
        n    = 0;
        done = 1'b0;
        while (!done && n < 4000) begin
            tick();
            n++;
            done = 1'b1;
            for (int i = 0; i < NI; i++)
                if (m_rd[i] != m_wr[i] || out_valid[i])
                    done = 1'b0;
        end
        for (int i = 0; i < NI; i++)
            chk(tag, i, 32'(m_rd[i]), 32'(m_wr[i]));
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    initial begin
        int   n;
        logic ok;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        rmode    = 3;
        lat_arm  = 1'b0;
        cyc      = 0;
        n_cmp    = 0;
        n_bad    = 0;

        // T1: long reset with random traffic
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'($urandom_range(1));
            in_data  = $urandom;
            tick();
        end
        in_valid = 1'b0;
        rst      = 1'b0;

        // T2: single frame, sink always ready, latency measured
        rmode   = 1;
        lat_arm = 1'b1;
        send(BW, 32'd0, 0);
        lat_arm = 1'b0;
        drain("t2_drain");
        for (int i = 0; i < NI; i++)
            chk("t2_lat_seen", i, 32'(lat_pend[i]), 32'd0);

        // T3: alternating then random backpressure
        rmode = 2;
        send(BW, 32'd0, 0);
        rmode = 3;
        send(BW, 32'd0, 25);
        drain("t3_drain");

        // T4: stalled sink, 300 samples, 44 dropped
        do_reset();
        rmode = 0;
        send(300, 32'd0, 0);
        tick();
        for (int i = 0; i < NI; i++) begin
            chk("t4_wr_pulses", i, 32'(n_we[i]), 32'd256);
            chk("t4_overflow", i, 32'(overflow[i]), 32'd1);
        end
        rmode = 1;
        drain("t4_drain");
        for (int i = 0; i < NI; i++)
            chk("t4_words", i, 32'(m_rd[i]), 32'd256);

        // T5: bank freed in the same cycle the writer needs it
        do_reset();
        rmode = 0;
        send(2 * BW, 32'h1000, 0);
        rmode = 4;
        n     = 0;
        ok    = 1'b0;
        while (!ok && n < 2000) begin
            tick();
            n++;
            ok = 1'b1;
            for (int i = 0; i < NI; i++)
                if (!(out_valid[i] && out_last[i] && m_rd[i] == BW - 1))
                    ok = 1'b0;
        end
        for (int i = 0; i < NI; i++)
            chk("t5_parked", i, 32'(m_rd[i]), 32'(BW - 1));
        rmode    = 1;
        in_valid = 1'b1;
        in_data  = 32'hC0FFEE;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < NI; i++) begin
            chk("t5_wr_en", i, 32'(ram_wr_en[i]), 32'd1);
            chk("t5_wr_addr", i, 32'(ram_wr_addr[i]), 32'd0);
            chk("t5_overflow", i, 32'(overflow[i]), 32'd0);
        end
        drain("t5_drain");

        // T6: reset in the middle of a frame read, then a clean frame
        do_reset();
        rmode = 1;
        send(BW, 32'h2000, 0);
        n = 0;
        while (m_rd[1] < 50 && n < 1000) begin
            tick();
            n++;
        end
        chk("t6_reached50", 1, 32'(m_rd[1]), 32'd50);
        do_reset();
        send(BW, 32'h3000, 0);
        drain("t6_drain");
        for (int i = 0; i < NI; i++)
            chk("t6_words", i, 32'(m_rd[i]), 32'(BW));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
